// File: rtl/wb_patch_master.sv
// Wishbone classic master moving one patch as a low/high pair of 32-bit beats.
// Holds one transaction in flight and reports completion, read data or a timeout.
module wb_patch_master #(
  parameter int          DATA_WIDTH = 11,
  parameter int          PATCH_SIZE = 5,
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          TIMEOUT    = 255,
  localparam int         PW         = DATA_WIDTH * PATCH_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_index,
  input  logic [PW-1:0]         cmd_wpatch,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PW-1:0]         rsp_rpatch,
  output logic                  rsp_err,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [31:0]           wbm_adr_o,
  output logic [31:0]           wbm_dat_o,
  input  logic [31:0]           wbm_dat_i,
  input  logic                  wbm_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rdat_q, rdat_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            cnt_inc;
  logic                  beat, tmo;
  logic [31:0]           base;

  assign beat    = (state_q == S_LO) || (state_q == S_HI);
  assign cnt_inc = cnt_q + 8'd1;
  // An ack in the expiry cycle wins over the timeout.
  assign tmo     = beat && !wbm_ack_i && (cnt_inc == 8'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wp_d    = wp_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          idx_d   = cmd_index;
          wp_d    = cmd_wpatch;
          rdat_d  = '0;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (wbm_ack_i) begin
          if (!we_q) rdat_d[31:0] = wbm_dat_i;
          cnt_d   = 8'd0;
          state_d = S_HI;
        end else if (tmo) begin
          rdat_d  = '0;
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HI: begin
        if (wbm_ack_i) begin
          if (!we_q) rdat_d[PW-1:32] = wbm_dat_i[PW-33:0];
          state_d = S_RSP;
        end else if (tmo) begin
          rdat_d  = '0;
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wp_q    <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wp_q    <= wp_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign base = BASE_ADDR + (32'(idx_q) << 3);

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RSP);
  assign rsp_rpatch = rdat_q;
  assign rsp_err    = err_q;

  assign wbm_cyc_o = beat;
  assign wbm_stb_o = beat;
  assign wbm_we_o  = beat & we_q;
  assign wbm_sel_o = beat ? 4'hF : 4'h0;

  always_comb begin
    wbm_adr_o = 32'd0;
    wbm_dat_o = 32'd0;
    if (state_q == S_LO) begin
      wbm_adr_o = base;
      wbm_dat_o = wp_q[31:0];
    end else if (state_q == S_HI) begin
      wbm_adr_o = base + 32'd4;
      wbm_dat_o = 32'(wp_q[PW-1:32]);
    end
  end

  // Read bits beyond the patch width are dropped.
  if (PW < 64) begin : g_unused
    logic unused_dat;
    assign unused_dat = ^wbm_dat_i[31:PW-32];
  end

endmodule
